ps2_scan_ctrl: RTL and testbench

Controller that drains the PS/2 keyboard receiver FIFO and turns raw set-2 scan bytes into key events. It sits directly downstream of the receiver and drives the receiver's `nextdata_n` pop strobe. It decodes the E0 (extended), F0 (break) and E1 (pause) prefixes, filters typematic repeats of the held key, and flags protocol and FIFO errors. Its outputs feed the display and ASCII front end.

---
 rtl/ps2_scan_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_ps2_scan_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_ctrl.sv
// rtl/ps2_scan_ctrl.sv - PS/2 set-2 scan byte decoder draining the receiver FIFO (optional ASCII lookup: PS2_SCAN_ASCII_EN)
module ps2_scan_ctrl (
    input  logic       clk,
    input  logic       clrn,
    input  logic       en,
    input  logic [7:0] kb_data,
    input  logic       kb_ready,
    input  logic       kb_overflow,
    output logic       kb_nextdata_n,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       key_repeat,
    output logic       key_held,
    output logic [7:0] make_count,
    output logic       proto_err,
    output logic       ovf_err,
    output logic [7:0] ascii
);

    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [7:0] byte_r, byte_nxt;
    logic       ext_pend, ext_pend_nxt;
    logic       brk_pend, brk_pend_nxt;
    logic [2:0] skip_cnt, skip_cnt_nxt;
    logic [7:0] held_code, held_code_nxt;
    logic       held_ext, held_ext_nxt;
    logic       nextdata_nxt, valid_nxt, ext_nxt, release_nxt, repeat_nxt;
    logic       held_nxt, perr_nxt, ovf_nxt;
    logic [7:0] code_nxt, count_nxt;

`ifdef PS2_SCAN_ASCII_EN
    logic [7:0] ascii_r, ascii_nxt;

    function automatic logic [7:0] set2_ascii(input logic [7:0] c);
        case (c)
            8'h1C: set2_ascii = 8'h61; 8'h32: set2_ascii = 8'h62; 8'h21: set2_ascii = 8'h63;
            8'h23: set2_ascii = 8'h64; 8'h24: set2_ascii = 8'h65; 8'h2B: set2_ascii = 8'h66;
            8'h34: set2_ascii = 8'h67; 8'h33: set2_ascii = 8'h68; 8'h43: set2_ascii = 8'h69;
            8'h3B: set2_ascii = 8'h6A; 8'h42: set2_ascii = 8'h6B; 8'h4B: set2_ascii = 8'h6C;
            8'h3A: set2_ascii = 8'h6D; 8'h31: set2_ascii = 8'h6E; 8'h44: set2_ascii = 8'h6F;
            8'h4D: set2_ascii = 8'h70; 8'h15: set2_ascii = 8'h71; 8'h2D: set2_ascii = 8'h72;
            8'h1B: set2_ascii = 8'h73; 8'h2C: set2_ascii = 8'h74; 8'h3C: set2_ascii = 8'h75;
            8'h2A: set2_ascii = 8'h76; 8'h1D: set2_ascii = 8'h77; 8'h22: set2_ascii = 8'h78;
            8'h35: set2_ascii = 8'h79; 8'h1A: set2_ascii = 8'h7A;
            8'h45: set2_ascii = 8'h30; 8'h16: set2_ascii = 8'h31; 8'h1E: set2_ascii = 8'h32;
            8'h26: set2_ascii = 8'h33; 8'h25: set2_ascii = 8'h34; 8'h2E: set2_ascii = 8'h35;
            8'h36: set2_ascii = 8'h36; 8'h3D: set2_ascii = 8'h37; 8'h3E: set2_ascii = 8'h38;
            8'h46: set2_ascii = 8'h39; 8'h29: set2_ascii = 8'h20;
            default: set2_ascii = 8'h00;
        endcase
    endfunction

    assign ascii = ascii_r;
`else
    assign ascii = 8'h00;
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state         <= IDLE;
            byte_r        <= 8'h00;
            ext_pend      <= 1'b0;
            brk_pend      <= 1'b0;
            skip_cnt      <= 3'd0;
            held_code     <= 8'h00;
            held_ext      <= 1'b0;
            kb_nextdata_n <= 1'b1;
            key_valid     <= 1'b0;
            key_code      <= 8'h00;
            key_ext       <= 1'b0;
            key_release   <= 1'b0;
            key_repeat    <= 1'b0;
            key_held      <= 1'b0;
            make_count    <= 8'h00;
            proto_err     <= 1'b0;
            ovf_err       <= 1'b0;
`ifdef PS2_SCAN_ASCII_EN
            ascii_r       <= 8'h00;
`endif
        end else begin
            state         <= state_nxt;
            byte_r        <= byte_nxt;
            ext_pend      <= ext_pend_nxt;
            brk_pend      <= brk_pend_nxt;
            skip_cnt      <= skip_cnt_nxt;
            held_code     <= held_code_nxt;
            held_ext      <= held_ext_nxt;
            kb_nextdata_n <= nextdata_nxt;
            key_valid     <= valid_nxt;
            key_code      <= code_nxt;
            key_ext       <= ext_nxt;
            key_release   <= release_nxt;
            key_repeat    <= repeat_nxt;
            key_held      <= held_nxt;
            make_count    <= count_nxt;
            proto_err     <= perr_nxt;
            ovf_err       <= ovf_nxt;
`ifdef PS2_SCAN_ASCII_EN
            ascii_r       <= ascii_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en && kb_ready) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_nxt      = byte_r;
        ext_pend_nxt  = ext_pend;
        brk_pend_nxt  = brk_pend;
        skip_cnt_nxt  = skip_cnt;
        held_code_nxt = held_code;
        held_ext_nxt  = held_ext;
        nextdata_nxt  = 1'b1;
        valid_nxt     = 1'b0;
        code_nxt      = key_code;
        ext_nxt       = key_ext;
        release_nxt   = key_release;
        repeat_nxt    = 1'b0;
        held_nxt      = key_held;
        count_nxt     = make_count;
        perr_nxt      = 1'b0;
        ovf_nxt       = ovf_err | kb_overflow;
`ifdef PS2_SCAN_ASCII_EN
        ascii_nxt     = ascii_r;
`endif

        if (state == IDLE && en && kb_ready) begin
            byte_nxt     = kb_data;
            nextdata_nxt = 1'b0;
        end

        if (state == ACK) begin
            // Pause (E1) is followed by seven bytes that carry no key information
            if (skip_cnt != 3'd0) begin
                skip_cnt_nxt = skip_cnt - 3'd1;
            end else if (byte_r == 8'hE1) begin
                skip_cnt_nxt = 3'd7;
                valid_nxt    = 1'b1;
                code_nxt     = 8'hE1;
                ext_nxt      = 1'b0;
                release_nxt  = 1'b0;
`ifdef PS2_SCAN_ASCII_EN
                ascii_nxt    = 8'h00;
`endif
            end else if (byte_r == 8'h00 || byte_r == 8'hFF || byte_r == 8'hFC || byte_r == 8'hFD) begin
                perr_nxt     = 1'b1;
                ext_pend_nxt = 1'b0;
                brk_pend_nxt = 1'b0;
            end else if (byte_r == 8'hAA || byte_r == 8'hFA || byte_r == 8'hEE) begin
                perr_nxt     = 1'b0;
            end else if (byte_r == 8'hE0) begin
                ext_pend_nxt = 1'b1;
            end else if (byte_r == 8'hF0) begin
                brk_pend_nxt = 1'b1;
            end else begin
                ext_pend_nxt = 1'b0;
                brk_pend_nxt = 1'b0;
                if (!brk_pend) begin
                    if (key_held && held_ext == ext_pend && held_code == byte_r) begin
                        repeat_nxt = 1'b1;
                    end else begin
                        valid_nxt     = 1'b1;
                        code_nxt      = byte_r;
                        ext_nxt       = ext_pend;
                        release_nxt   = 1'b0;
                        held_code_nxt = byte_r;
                        held_ext_nxt  = ext_pend;
                        held_nxt      = 1'b1;
                        count_nxt     = make_count + 8'd1;
`ifdef PS2_SCAN_ASCII_EN
                        ascii_nxt     = ext_pend ? 8'h00 : set2_ascii(byte_r);
`endif
                    end
                end else begin
                    valid_nxt   = 1'b1;
                    code_nxt    = byte_r;
                    ext_nxt     = ext_pend;
                    release_nxt = 1'b1;
                    if (held_ext == ext_pend && held_code == byte_r) held_nxt = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// tb/tb_ps2_scan_ctrl.sv - directed self-checking bench for ps2_scan_ctrl
module tb_ps2_scan_ctrl;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       en = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_ready = 1'b0;
    logic       kb_overflow = 1'b0;
    logic       kb_nextdata_n, key_valid, key_ext, key_release, key_repeat, key_held;
    logic       proto_err, ovf_err;
    logic [7:0] key_code, make_count, ascii;

    ps2_scan_ctrl dut (
        .clk(clk), .clrn(clrn), .en(en), .kb_data(kb_data), .kb_ready(kb_ready),
        .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n), .key_valid(key_valid),
        .key_code(key_code), .key_ext(key_ext), .key_release(key_release),
        .key_repeat(key_repeat), .key_held(key_held), .make_count(make_count),
        .proto_err(proto_err), .ovf_err(ovf_err), .ascii(ascii)
    );

    always #5 clk = ~clk;

    // FIFO model: main process writes mem/wr_ptr, the receiver process owns rd_ptr
    logic [7:0]  mem [64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          cyc = 0;
    int          pop_cnt = 0;
    int          rep_cnt = 0;
    int          perr_cnt = 0;
    int          dbl_low = 0;
    logic        prev_low = 1'b0;
    logic [10:0] ev_q [$];
    int          low_q [$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (key_valid) ev_q.push_back({key_held, key_release, key_ext, key_code});
        if (key_repeat) rep_cnt++;
        if (proto_err) perr_cnt++;
        if (!kb_nextdata_n) begin
            if (prev_low) dbl_low++;
            low_q.push_back(cyc);
            pop_cnt++;
            if (rd_ptr != wr_ptr) rd_ptr++;
        end
        prev_low = !kb_nextdata_n;
        kb_ready = (rd_ptr != wr_ptr);
        kb_data  = (rd_ptr != wr_ptr) ? mem[rd_ptr % 64] : 8'h00;
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 64] = b;
        wr_ptr++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (rd_ptr != wr_ptr && t < 200) begin
            step(1);
            t++;
        end
        check("drain_timeout", (t < 200) ? 32'd1 : 32'd0, 32'd1);
        step(3);
    endtask

    int eb, rb, pb, lb, pc;

    initial begin
        step(2);
        check("rst_nextdata", kb_nextdata_n, 1'b1);
        check("rst_valid",    key_valid,     1'b0);
        check("rst_code",     key_code,      8'h00);
        check("rst_held",     key_held,      1'b0);
        check("rst_count",    make_count,    8'h00);
        check("rst_ovf",      ovf_err,       1'b0);
        check("rst_ascii",    ascii,         8'h00);
        clrn = 1'b1;
        en   = 1'b1;
        step(2);

        // make then break of 'A'
        eb = ev_q.size();
        push(8'h1C); push(8'hF0); push(8'h1C);
        drain();
        check("a_events", ev_q.size() - eb, 2);
        check("a_make",   ev_q[eb],   11'h41C);
        check("a_break",  ev_q[eb+1], 11'h21C);
        check("a_count",  make_count, 8'd1);
`ifdef PS2_SCAN_ASCII_EN
        check("a_ascii",  ascii, 8'h61);
`else
        check("a_ascii",  ascii, 8'h00);
`endif

        // extended arrow make/break
        eb = ev_q.size();
        push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
        drain();
        check("ext_events", ev_q.size() - eb, 2);
        check("ext_make",   ev_q[eb],   11'h575);
        check("ext_break",  ev_q[eb+1], 11'h375);

        // typematic repeats
        eb = ev_q.size();
        rb = rep_cnt;
        push(8'h1C); push(8'h1C); push(8'h1C);
        drain();
        check("rep_events", ev_q.size() - eb, 1);
        check("rep_pulses", rep_cnt - rb, 2);
        check("rep_count",  make_count, 8'd3);
        check("rep_held",   key_held, 1'b1);

        // pause sequence skips seven bytes
        eb = ev_q.size();
        push(8'hE1); push(8'h14); push(8'h77); push(8'hE1);
        push(8'hF0); push(8'h14); push(8'hF0); push(8'h77); push(8'h29);
        drain();
        check("pause_events", ev_q.size() - eb, 2);
        check("pause_e1",     ev_q[eb],   11'h4E1);
        check("pause_29",     ev_q[eb+1], 11'h429);
        check("pause_count",  make_count, 8'd4);

        // protocol error clears a pending E0
        eb = ev_q.size();
        pb = perr_cnt;
        push(8'hE0); push(8'hFF); push(8'h1C);
        drain();
        check("perr_pulse",  perr_cnt - pb, 1);
        check("perr_events", ev_q.size() - eb, 1);
        check("perr_event",  ev_q[eb], 11'h41C);

        // back-to-back: hold off with en=0, then pop every 2 cycles
        en = 1'b0;
        pc = pop_cnt;
        push(8'h15); push(8'h1D); push(8'h24); push(8'h2D); push(8'h2C); push(8'h35);
        step(6);
        check("en0_no_pop", pop_cnt - pc, 0);
        lb = low_q.size();
        en = 1'b1;
        drain();
        check("b2b_pops", low_q.size() - lb, 6);
        for (int i = lb + 1; i < low_q.size(); i++)
            check("b2b_gap", low_q[i] - low_q[i-1], 2);
        check("b2b_count", make_count, 8'd11);

        // en dropped during ACK: in-flight pop completes, then parks
        pc = pop_cnt;
        push(8'h3C); push(8'h43); push(8'h44); push(8'h4D);
        for (int t = 0; t < 20 && pop_cnt == pc; t++) step(1);
        en = 1'b0;
        step(6);
        check("en_ack_pops", pop_cnt - pc, 1);
        check("en_ack_left", wr_ptr - rd_ptr, 3);
        en = 1'b1;
        drain();
        check("en_ack_count", make_count, 8'd15);

        // overflow is sticky
        kb_overflow = 1'b1;
        step(1);
        kb_overflow = 1'b0;
        step(5);
        check("ovf_sticky", ovf_err, 1'b1);

        // reset while the pop is in flight
        pc = pop_cnt;
        push(8'h1A);
        for (int t = 0; t < 20 && pop_cnt == pc; t++) step(1);
        check("ack_nextdata_low", kb_nextdata_n, 1'b0);
        clrn = 1'b0;
        #1;
        check("rst_ack_nextdata", kb_nextdata_n, 1'b1);
        check("rst_ack_ovf",      ovf_err,       1'b0);
        check("rst_ack_count",    make_count,    8'h00);
        check("rst_ack_held",     key_held,      1'b0);
        check("rst_ack_code",     key_code,      8'h00);
        step(2);
        clrn = 1'b1;
        step(2);
        check("never_double_low", dbl_low, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
